// File: rtl/fibonacci_gen_multi_if.sv
// Output beat stream of fibonacci_gen_multi.
//   out_valid  beat available (producer -> consumer)
//   out_ready  consumer accepts beat (consumer -> producer)
//   out_num    LANES terms; lane i = bits [i*WIDTH +: WIDTH], lane 0 earliest
//   out_mask   lane i carries a real term
//   out_last   final beat of the run
// master = generator side, slave = consumer side.
interface fibonacci_gen_multi_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 2
);
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_num;
  logic [LANES-1:0]       out_mask;
  logic                   out_last;

  modport master (
    output out_valid,
    output out_num,
    output out_mask,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_num,
    input  out_mask,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fibonacci_gen_multi.sv
// Fibonacci sequence generator emitting LANES consecutive terms per beat on a
// valid/ready stream, with programmable seeds, term count and a sticky overflow flag.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start     start request, sampled only when idle
//   seed_a    term 0 of the sequence
//   seed_b    term 1 of the sequence
//   len       total terms to emit; 0 ignores the request
//   busy      high while a run is in progress
//   overflow  sticky: an emitted term exceeded 2^WIDTH-1 (cleared by accepted start)
//   out_if    beat stream (fibonacci_gen_multi_if master modport)
//
// Configuration macro FIB_SATURATE_EN: when defined, sums with carry-out clamp to
// all-ones instead of wrapping mod 2^WIDTH. Overflow reporting is identical.
module fibonacci_gen_multi #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 2,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             overflow,
  fibonacci_gen_multi_if.master out_if
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;    // terms k and k+1, k = first un-emitted term
  logic             fa_q, fb_q;  // true value of a_q / b_q exceeded WIDTH bits
  logic [LEN_W-1:0] rem_q;
  logic             ovf_q;
  logic             busy_q;
  logic             valid_q;

  // term[j] = T(k+j); terms LANES and LANES+1 seed the next beat.
  logic [WIDTH-1:0] term [LANES+2];
  logic             flag [LANES+2];
  logic [WIDTH:0]   sum;

  always_comb begin
    sum     = '0;
    term[0] = a_q;
    term[1] = b_q;
    flag[0] = fa_q;
    flag[1] = fb_q;
    for (int unsigned j = 2; j < LANES + 2; j++) begin
      sum = {1'b0, term[j-1]} + {1'b0, term[j-2]};
`ifdef FIB_SATURATE_EN
      term[j] = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
      term[j] = sum[WIDTH-1:0];
`endif
      // Once any term overflows, every later term's true value does too.
      flag[j] = sum[WIDTH] | flag[j-1] | flag[j-2];
    end
  end

  logic             last;
  logic             beat_ovf;
  logic             xfer;
  logic [LANES-1:0] mask;
  logic [LANES*WIDTH-1:0] num;

  assign last = valid_q && (rem_q <= LEN_W'(LANES));
  assign xfer = valid_q && out_if.out_ready;

  always_comb begin
    mask     = '0;
    num      = '0;
    beat_ovf = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      mask[i] = valid_q && (rem_q > LEN_W'(i));
      if (mask[i]) begin
        num[i*WIDTH +: WIDTH] = term[i];
        beat_ovf              = beat_ovf | flag[i];
      end
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_num   = num;
  assign out_if.out_mask  = mask;
  assign out_if.out_last  = last;
  assign busy             = busy_q;
  assign overflow         = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      fa_q    <= 1'b0;
      fb_q    <= 1'b0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && (len != '0)) begin
            state_q <= StRun;
            a_q     <= seed_a;
            b_q     <= seed_b;
            fa_q    <= 1'b0;
            fb_q    <= 1'b0;
            rem_q   <= len;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        StRun: begin
          if (xfer) begin
            a_q  <= term[LANES];
            b_q  <= term[LANES+1];
            fa_q <= flag[LANES];
            fb_q <= flag[LANES+1];
            if (beat_ovf) ovf_q <= 1'b1;
            if (last) begin
              // Zero remaining keeps mask and data at 0 while idle.
              state_q <= StIdle;
              rem_q   <= '0;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
            end else begin
              rem_q <= rem_q - LEN_W'(LANES);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
